// File: rtl/width_resize_pipe.sv
`timescale 1ns/1ps
// Purpose : IN_W -> OUT_W width converter (truncate / sign-truncate / unsigned
//           saturate / signed saturate chosen per beat) feeding a DEPTH-entry
//           FIFO, with a per-beat overflow flag and a saturating overflow counter.
// Latency : 1 cycle into an empty buffer. A beat accepted at edge N is visible at
//           the head after edge N.
// Backpr. : in_ready = (occupancy < DEPTH). It depends only on registered state, so
//           out_ready never reaches in_ready combinationally. A pop from a full
//           buffer frees the slot for the following cycle, not the current one.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data (IN_W) and in_mode (2) carry the beat
//   out_valid/out_ready output handshake; out_data (OUT_W) and out_ovf give the head
//                       entry. Both are forced to 0 while the buffer is empty.
//   clr_count           synchronous clear of ovf_count. It wins over an increment.
//   ovf_count (CNT_W)   accepted beats with ovf=1. The count saturates at all-ones.
module width_resize_pipe #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Signed saturation limits in OUT_W bits: 100..0 and 011..1.
    localparam logic [OUT_W-1:0] SMIN    = OUT_W'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0] SMAX    = ~SMIN;
    localparam logic [OUT_W-1:0] UMAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Conversion. It is evaluated on the incoming beat and stored with it.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] w_cv_dat;
    logic             w_cv_ovf;

    generate
        if (IN_W > OUT_W) begin : g_narrow
            localparam int D_W = IN_W - OUT_W;

            logic [D_W-1:0]   w_disc;
            logic [OUT_W-1:0] w_low;
            logic             w_any_disc;
            logic             w_not_sext;

            assign w_disc     = in_data[IN_W-1:OUT_W];
            assign w_low      = in_data[OUT_W-1:0];
            assign w_any_disc = |w_disc;
            // The value fits in OUT_W signed bits exactly when the discarded bits
            // all copy the new sign bit. The same test drives both signed modes.
            assign w_not_sext = (w_disc != {D_W{in_data[OUT_W-1]}});

            always_comb begin
                w_cv_dat = w_low;
                w_cv_ovf = 1'b0;
                case (in_mode)
                    2'b00: begin
                        w_cv_ovf = w_any_disc;
                    end
                    2'b01: begin
                        w_cv_ovf = w_not_sext;
                    end
                    2'b10: begin
                        if (w_any_disc) begin
                            w_cv_dat = UMAX;
                            w_cv_ovf = 1'b1;
                        end
                    end
                    default: begin
                        // Out of range. The input MSB tells which rail to clamp to.
                        if (w_not_sext) begin
                            w_cv_dat = in_data[IN_W-1] ? SMIN : SMAX;
                            w_cv_ovf = 1'b1;
                        end
                    end
                endcase
            end
        end else begin : g_wide
            // Widening or equal width cannot lose information.
            // in_mode[0] selects sign extension and in_mode[1] has no effect here.
            always_comb begin
                w_cv_ovf = 1'b0;
                w_cv_dat = in_mode[0] ? OUT_W'($signed(in_data)) : OUT_W'(in_data);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem_dat [DEPTH];
    logic             r_mem_ovf [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (r_occ < OCC_W'(DEPTH));
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid && in_ready && !reset;
    assign w_pop     = out_valid && out_ready && !reset;

    // The head is gated so that stale storage never shows on an idle output.
    assign out_data  = out_valid ? r_mem_dat[r_rd_ptr] : '0;
    assign out_ovf   = out_valid ? r_mem_ovf[r_rd_ptr] : 1'b0;
    assign ovf_count = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (clr_count) begin
                r_cnt <= '0;
            end else if (w_push && w_cv_ovf && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Storage needs no reset because the outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dat[r_wr_ptr] <= w_cv_dat;
            r_mem_ovf[r_wr_ptr] <= w_cv_ovf;
        end
    end

endmodule

// File: tb/tb_width_resize_pipe.sv
`timescale 1ns/1ps
// Bench for width_resize_pipe. Three instances share one stimulus stream:
//   k=0: IN_W=32 OUT_W=4 CNT_W=8   k=1: IN_W=32 OUT_W=4 CNT_W=2   k=2: IN_W=4 OUT_W=8
// Each accepted beat pushes its expected result, from an arithmetic model, into a
// per-instance queue. A negedge monitor pops entries and compares them.
module tb_width_resize_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_ready = 1'b0;
    logic        clr_count = 1'b0;

    logic       a_in_ready, a_out_valid, a_out_ovf;
    logic [3:0] a_out_data;
    logic [7:0] a_ovf_count;
    logic       b_in_ready, b_out_valid, b_out_ovf;
    logic [3:0] b_out_data;
    logic [1:0] b_ovf_count;
    logic       c_in_ready, c_out_valid, c_out_ovf;
    logic [7:0] c_out_data;
    logic [7:0] c_ovf_count;

    width_resize_pipe #(.IN_W(32), .OUT_W(4), .DEPTH(2), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf),
        .clr_count(clr_count), .ovf_count(a_ovf_count));

    width_resize_pipe #(.IN_W(32), .OUT_W(4), .DEPTH(2), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf),
        .clr_count(clr_count), .ovf_count(b_ovf_count));

    width_resize_pipe #(.IN_W(4), .OUT_W(8), .DEPTH(2), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data[3:0]), .in_mode(in_mode), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_data(c_out_data), .out_ovf(c_out_ovf),
        .clr_count(clr_count), .ovf_count(c_ovf_count));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    int iw   [3] = '{32, 32, 4};
    int ow   [3] = '{4, 4, 8};
    int cmax [3] = '{255, 3, 255};

    longint unsigned sbq   [3][$];
    longint unsigned cnt_m [3];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: value-range arithmetic on the integer value.
    // Returns {ovf at bit 32, data in the low bits}.
    function automatic longint unsigned model(int in_w, int out_w, longint unsigned d,
                                              logic [1:0] mode);
        longint unsigned u, o, omask;
        longint          s, lim, smax, smin;
        bit              v;
        u = d & ((64'd1 << in_w) - 1);
        if (u[in_w-1]) s = longint'(u) - (longint'(1) << in_w);
        else           s = longint'(u);
        lim   = longint'(1) << out_w;
        omask = $unsigned(lim) - 1;
        smax  = (longint'(1) << (out_w - 1)) - 1;
        smin  = -(longint'(1) << (out_w - 1));
        v = 1'b0;
        if (out_w >= in_w) begin
            o = (mode[0] ? $unsigned(s) : u) & omask;
        end else begin
            case (mode)
                2'd0: begin o = u & omask; v = (u >= $unsigned(lim)); end
                2'd1: begin o = u & omask; v = (s > smax) || (s < smin); end
                2'd2: begin v = (u >= $unsigned(lim)); o = v ? omask : (u & omask); end
                default: begin
                    if (s > smax)      begin o = $unsigned(smax); v = 1'b1; end
                    else if (s < smin) begin o = $unsigned(smin) & omask; v = 1'b1; end
                    else               begin o = u & omask; end
                end
            endcase
        end
        if (v) o = o | 64'h1_0000_0000;
        return o;
    endfunction

    // One clock cycle: sample the handshake at negedge, then update the model after
    // the rising edge. Time is always advanced through this task.
    task automatic tick();
        bit              acc [3];
        longint unsigned r   [3];
        bit              rs, cl;
        @(negedge clk);
        acc[0] = in_valid && a_in_ready && !reset;
        acc[1] = in_valid && b_in_ready && !reset;
        acc[2] = in_valid && c_in_ready && !reset;
        for (int k = 0; k < 3; k++) r[k] = model(iw[k], ow[k], {32'b0, in_data}, in_mode);
        rs = reset;
        cl = clr_count;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rs) begin
                sbq[k].delete();
                cnt_m[k] = 0;
            end else begin
                if (acc[k]) sbq[k].push_back(r[k]);
                if (cl) cnt_m[k] = 0;
                else if (acc[k] && r[k][32] && cnt_m[k] < longint'(cmax[k])) cnt_m[k]++;
            end
        end
    endtask

    task automatic mon(int k, logic vld, logic [63:0] dat, logic ovf, logic [63:0] cnt);
        longint unsigned e;
        chk($sformatf("out_valid[%0d]", k), {63'b0, vld}, {63'b0, sbq[k].size() != 0});
        if (vld && out_ready && sbq[k].size() != 0) begin
            e = sbq[k].pop_front();
            chk($sformatf("out_data[%0d]", k), dat, e & 64'hFFFF_FFFF);
            chk($sformatf("out_ovf[%0d]", k), {63'b0, ovf}, e >> 32);
        end else if (!vld) begin
            chk($sformatf("idle_data[%0d]", k), dat, 64'd0);
            chk($sformatf("idle_ovf[%0d]", k), {63'b0, ovf}, 64'd0);
        end
        chk($sformatf("ovf_count[%0d]", k), cnt, cnt_m[k]);
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            mon(0, a_out_valid, {60'b0, a_out_data}, a_out_ovf, {56'b0, a_ovf_count});
            mon(1, b_out_valid, {60'b0, b_out_data}, b_out_ovf, {62'b0, b_ovf_count});
            mon(2, c_out_valid, {56'b0, c_out_data}, c_out_ovf, {56'b0, c_ovf_count});
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_out_valid", {63'b0, a_out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, a_in_ready}, 64'd1);
        chk("rst_out_data", {60'b0, a_out_data}, 64'd0);
        chk("rst_out_ovf", {63'b0, a_out_ovf}, 64'd0);
        chk("rst_ovf_count", {56'b0, a_ovf_count}, 64'd0);
        chk("rst_ovf_count_b", {62'b0, b_ovf_count}, 64'd0);
    endtask

    // Offer one beat with out_ready=1. The head must show it right after the accept edge.
    task automatic one(input logic [31:0] d, input logic [1:0] m, input logic [3:0] ea,
                       input logic eo, input bit do_c = 1'b0, input logic [7:0] ec = 8'h0);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        tick();
        in_valid = 1'b0;
        chk("lat_valid", {63'b0, a_out_valid}, 64'd1);
        chk($sformatf("dir_data %h/%0d", d, m), {60'b0, a_out_data}, {60'b0, ea});
        chk($sformatf("dir_ovf %h/%0d", d, m), {63'b0, a_out_ovf}, {63'b0, eo});
        if (do_c) begin
            chk($sformatf("dir_c_data %h/%0d", d[3:0], m), {56'b0, c_out_data}, {56'b0, ec});
            chk("dir_c_ovf", {63'b0, c_out_ovf}, 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        tick();
        do_reset();
        started = 1'b1;

        // Truncation. The second beat loses bit 4.
        out_ready = 1'b1;
        one(32'h0000_0008, 2'd0, 4'h8, 1'b0);
        one(32'h0000_0018, 2'd0, 4'h8, 1'b1);
        chk("t1_ovf_count", {56'b0, a_ovf_count}, 64'd1);
        tick();

        // Unsigned saturate and sign-truncate.
        one(32'h0000_0018, 2'd2, 4'hF, 1'b1);
        one(32'h0000_0008, 2'd1, 4'h8, 1'b1);
        one(32'hFFFF_FFFE, 2'd1, 4'hE, 1'b0);
        // Signed saturate: both rails and the in-range case.
        one(32'hFFFF_FFF0, 2'd3, 4'h8, 1'b1);
        one(32'h0000_0020, 2'd3, 4'h7, 1'b1);
        one(32'hFFFF_FFFD, 2'd3, 4'hD, 1'b0);
        tick();
        tick();

        // Backpressure. The third beat waits until the buffer has room.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_data   = 32'h0000_0001; tick();
        in_data   = 32'h0000_0002; tick();
        in_data   = 32'h0000_0003;
        chk("bp_full", {63'b0, a_in_ready}, 64'd0);
        tick();
        tick();
        chk("bp_stall", {63'b0, a_in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();      // pop from full, no push on the same edge
        chk("bp_room", {63'b0, a_in_ready}, 64'd1);
        tick();      // C accepted here
        in_valid = 1'b0;
        repeat (3) tick();

        // Reset while two entries are buffered, then a clean beat.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0018; tick();
        in_data   = 32'h0000_0005; tick();
        in_valid  = 1'b0;
        chk("pre_rst_full", {63'b0, a_in_ready}, 64'd0);
        do_reset();
        out_ready = 1'b1;
        one(32'h0000_0003, 2'd0, 4'h3, 1'b0);
        tick();

        // Counter saturation (CNT_W=2), then a clear that wins over an increment.
        in_valid = 1'b1;
        in_data  = 32'h0000_0018;
        in_mode  = 2'd0;
        repeat (5) tick();
        chk("sat_b", {62'b0, b_ovf_count}, 64'd3);
        chk("sat_a", {56'b0, a_ovf_count}, 64'd5);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        in_valid  = 1'b0;
        chk("clr_b", {62'b0, b_ovf_count}, 64'd0);
        chk("clr_a", {56'b0, a_ovf_count}, 64'd0);
        tick();

        // Widening instance: sign- versus zero-extension of 4'hA.
        one(32'h0000_000A, 2'd1, 4'hA, 1'b1, 1'b1, 8'hFA);
        one(32'h0000_000A, 2'd0, 4'hA, 1'b0, 1'b1, 8'h0A);
        tick();

        // Randomised traffic with random backpressure, clears and resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       in_data = $urandom;
                1:       in_data = $urandom_range(0, 40);
                2:       in_data = 32'hFFFF_FFFF - $urandom_range(0, 40);
                default: in_data = 32'($urandom_range(0, 15)) << $urandom_range(0, 28);
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
            clr_count = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset     = 1'b0;
        clr_count = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
